// File: rtl/op_scheduler.sv
// op_scheduler: shares one combinational 16-bit operator core between two
// requesters. It arbitrates round-robin, holds the operands on the core for
// SETTLE_CYCLES, captures the selected result and flags, and then returns
// them to the requester that owns the operation.
module op_scheduler #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_overflow,
  output logic        rsp_prec_lost,
  output logic [15:0] core_num1,
  output logic [15:0] core_num2,
  input  logic [15:0] core_fixA,
  input  logic [15:0] core_fixM,
  input  logic [15:0] core_floA,
  input  logic [15:0] core_floM,
  input  logic [3:0]  core_overflow,
  input  logic        core_prec_lost,
  output logic        busy
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned OP_W   = 2;

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  state_t            state;
  state_t            state_next;
  logic              last;
  logic              owner;
  logic [CNT_W-1:0]  cnt;
  logic [OP_W-1:0]   op;

  logic              grant_idx;
  logic              accept;
  logic [OP_W-1:0]   sel_op;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [DATA_W-1:0] cap_result;
  logic              cap_overflow;
  logic              cap_prec_lost;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SETTLE;
      SETTLE:  if (cnt == '0) state_next = RESP;
      RESP:    if (rsp_ready[owner]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant, request selection and result mux; req_ready is the only combinational output
  always_comb begin
    req_ready     = '0;
    grant_idx     = 1'b0;
    sel_op        = '0;
    sel_a         = '0;
    sel_b         = '0;
    cap_result    = '0;
    cap_overflow  = 1'b0;
    cap_prec_lost = 1'b0;

    // With both requests pending the one not served last wins
    grant_idx = (req_valid == 2'b11) ? ~last : req_valid[1];
    if (!rst && state == IDLE && req_valid != 2'b00)
      req_ready = grant_idx ? 2'b10 : 2'b01;

    sel_op = grant_idx ? req_op[3:2]   : req_op[1:0];
    sel_a  = grant_idx ? req_a[31:16]  : req_a[15:0];
    sel_b  = grant_idx ? req_b[31:16]  : req_b[15:0];

    // The core's overflow bits are ordered fixA, fixM, floM, floA
    case (op)
      2'b00: begin cap_result = core_fixA; cap_overflow = core_overflow[0]; end
      2'b01: begin
        cap_result    = core_fixM;
        cap_overflow  = core_overflow[1];
        cap_prec_lost = core_prec_lost;
      end
      2'b10: begin cap_result = core_floA; cap_overflow = core_overflow[3]; end
      default: begin cap_result = core_floM; cap_overflow = core_overflow[2]; end
    endcase
  end

  assign accept = |req_ready;

  // Datapath: request latch, settle counter, operand and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      last          <= 1'b1;
      owner         <= 1'b0;
      cnt           <= '0;
      op            <= '0;
      core_num1     <= '0;
      core_num2     <= '0;
      rsp_valid     <= '0;
      rsp_result    <= '0;
      rsp_overflow  <= 1'b0;
      rsp_prec_lost <= 1'b0;
      busy          <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      if (accept) begin
        op        <= sel_op;
        owner     <= grant_idx;
        last      <= grant_idx;
        cnt       <= CNT_W'(SETTLE_CYCLES - 1);
        core_num1 <= sel_a;
        core_num2 <= sel_b;
      end
      if (state == SETTLE) begin
        if (cnt != '0) begin
          cnt <= cnt - CNT_W'(1);
        end else begin
          rsp_result    <= cap_result;
          rsp_overflow  <= cap_overflow;
          rsp_prec_lost <= cap_prec_lost;
          rsp_valid     <= owner ? 2'b10 : 2'b01;
        end
      end
      if (state == RESP && rsp_ready[owner])
        rsp_valid <= '0;
    end
  end

endmodule

// File: tb/tb_op_scheduler.sv
// Directed testbench for op_scheduler with a small stand-in for the
// operator core: fixed-point paths are computed (Q8.8), float paths are
// looked up for the vectors used, and a stub mode returns fixed markers.
`timescale 1ns/1ps
module tb_op_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [1:0]  rsp_valid, rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_overflow, rsp_prec_lost;
  logic [15:0] core_num1, core_num2;
  logic [15:0] core_fixA, core_fixM, core_floA, core_floM;
  logic [3:0]  core_overflow;
  logic        core_prec_lost;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic        stub_mode = 1'b0;
  logic [3:0]  stub_ovf  = 4'b0;
  logic        stub_pl   = 1'b0;

  logic [16:0] sum17;
  logic [31:0] prod32;

  always #5 clk = ~clk;

  op_scheduler #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_overflow(rsp_overflow), .rsp_prec_lost(rsp_prec_lost),
    .core_num1(core_num1), .core_num2(core_num2),
    .core_fixA(core_fixA), .core_fixM(core_fixM),
    .core_floA(core_floA), .core_floM(core_floM),
    .core_overflow(core_overflow), .core_prec_lost(core_prec_lost),
    .busy(busy)
  );

  assign sum17  = {1'b0, core_num1} + {1'b0, core_num2};
  assign prod32 = 32'(core_num1) * 32'(core_num2);

  // Stand-in operator core
  always_comb begin
    core_fixA = 16'h0; core_fixM = 16'h0; core_floA = 16'h0; core_floM = 16'h0;
    core_overflow = 4'b0; core_prec_lost = 1'b0;
    if (stub_mode) begin
      core_fixA = 16'h1111; core_fixM = 16'h2222;
      core_floA = 16'h3333; core_floM = 16'h4444;
      core_overflow = stub_ovf; core_prec_lost = stub_pl;
    end else begin
      core_fixA        = sum17[15:0];
      core_overflow[0] = sum17[16];
      core_fixM        = prod32[23:8];
      core_overflow[1] = |prod32[31:24];
      core_prec_lost   = |prod32[7:0];
      if (core_num1 == 16'h3C00 && core_num2 == 16'h3C00) core_floA = 16'h4000;
      if (core_num1 == 16'h4000 && core_num2 == 16'h4200) core_floM = 16'h4600;
      if (core_num1 == 16'h7BFF && core_num2 == 16'h7BFF) begin
        core_floM = 16'h7C00; core_overflow[2] = 1'b1;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0;
  endtask

  // Issue one request and collect its response; ok=0 on a timeout
  task automatic do_op(input int idx, input logic [1:0] op, input logic [15:0] a,
                       input logic [15:0] b, output logic [15:0] res, output logic ovf,
                       output logic pl, output logic [1:0] vld, output bit ok);
    int n;
    ok = 1'b1; res = '0; ovf = 1'b0; pl = 1'b0; vld = '0;
    @(negedge clk);
    req_valid[idx] = 1'b1;
    req_op[2*idx +: 2] = op; req_a[16*idx +: 16] = a; req_b[16*idx +: 16] = b;
    #1;
    n = 0;
    while (!req_ready[idx] && n < 20) begin @(negedge clk); #1; n++; end
    if (!req_ready[idx]) begin ok = 1'b0; req_valid[idx] = 1'b0; return; end
    @(negedge clk); req_valid[idx] = 1'b0; #1;
    n = 0;
    while (rsp_valid == 2'b00 && n < 30) begin @(negedge clk); #1; n++; end
    if (rsp_valid == 2'b00) begin ok = 1'b0; return; end
    res = rsp_result; ovf = rsp_overflow; pl = rsp_prec_lost; vld = rsp_valid;
    rsp_ready[idx] = 1'b1;
    @(negedge clk); rsp_ready[idx] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b11;
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    checks++;
    if ({rsp_valid, busy, rsp_overflow, rsp_prec_lost} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got=%b exp=00000", {rsp_valid, busy, rsp_overflow, rsp_prec_lost});
    end
    checks++;
    if ({core_num1, core_num2, rsp_result} !== 48'h0) begin
      errors++; $display("FAIL reset_data got=%h exp=0", {core_num1, core_num2, rsp_result});
    end
    req_valid = 2'b00;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_single_fixed_add();
    @(negedge clk);
    req_valid = 2'b01; req_op[1:0] = 2'b00; req_a[15:0] = 16'h001B; req_b[15:0] = 16'h002A;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL add_ready got=%b exp=01", req_ready); end
    @(negedge clk); req_valid = 2'b00; #1;  // T+1
    checks++;
    if (core_num1 !== 16'h001B || core_num2 !== 16'h002A || busy !== 1'b1) begin
      errors++; $display("FAIL add_operands got=%h/%h busy=%b exp=001b/002a busy=1", core_num1, core_num2, busy);
    end
    @(negedge clk); #1;  // T+2
    checks++;
    if (rsp_valid !== 2'b00) begin errors++; $display("FAIL add_early_rsp got=%b exp=00", rsp_valid); end
    @(negedge clk); #1;  // T+3
    checks++;
    if (rsp_valid !== 2'b01 || rsp_result !== 16'h0045 || rsp_overflow !== 1'b0 || rsp_prec_lost !== 1'b0) begin
      errors++; $display("FAIL add_rsp got=%b %h %b %b exp=01 0045 0 0", rsp_valid, rsp_result, rsp_overflow, rsp_prec_lost);
    end
    rsp_ready = 2'b01;
    @(negedge clk); rsp_ready = 2'b00; #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
      errors++; $display("FAIL add_idle got busy=%b vld=%b exp=0 00", busy, rsp_valid);
    end
  endtask

  task automatic test_fixed_mul();
    logic [15:0] r; logic o, p; logic [1:0] v; bit ok;
    do_op(1, 2'b01, 16'h001B, 16'h002A, r, o, p, v, ok);
    checks++;
    if (!ok || v !== 2'b10 || r !== 16'h0004 || p !== 1'b1 || o !== 1'b0) begin
      errors++; $display("FAIL fixmul got ok=%0d vld=%b res=%h ovf=%b pl=%b exp=1 10 0004 0 1", ok, v, r, o, p);
    end
  endtask

  task automatic test_float();
    logic [15:0] r; logic o, p; logic [1:0] v; bit ok;
    do_op(0, 2'b10, 16'h3C00, 16'h3C00, r, o, p, v, ok);
    checks++;
    if (!ok || r !== 16'h4000 || o !== 1'b0 || p !== 1'b0) begin
      errors++; $display("FAIL floadd got ok=%0d res=%h ovf=%b pl=%b exp=1 4000 0 0", ok, r, o, p);
    end
    do_op(1, 2'b11, 16'h4000, 16'h4200, r, o, p, v, ok);
    checks++;
    if (!ok || v !== 2'b10 || r !== 16'h4600 || o !== 1'b0) begin
      errors++; $display("FAIL flomul got ok=%0d vld=%b res=%h ovf=%b exp=1 10 4600 0", ok, v, r, o);
    end
    do_op(0, 2'b11, 16'h7BFF, 16'h7BFF, r, o, p, v, ok);
    checks++;
    if (!ok || r !== 16'h7C00 || o !== 1'b1 || p !== 1'b0) begin
      errors++; $display("FAIL flomul_ovf got ok=%0d res=%h ovf=%b pl=%b exp=1 7c00 1 0", ok, r, o, p);
    end
  endtask

  // Each op must take its own result and overflow bit, and precision-lost only for fixed mul
  task automatic test_flag_select();
    logic [15:0] r; logic o, p; logic [1:0] v; bit ok;
    logic [15:0] exp_res [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    logic [3:0]  exp_bit [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0100};
    stub_mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      stub_ovf = exp_bit[k]; stub_pl = 1'b1;
      do_op(k % 2, 2'(k), 16'h0001, 16'h0002, r, o, p, v, ok);
      checks++;
      if (!ok || r !== exp_res[k] || o !== 1'b1 || p !== (k == 1)) begin
        errors++; $display("FAIL select_on op=%0d got ok=%0d res=%h ovf=%b pl=%b exp=%h 1 %0d", k, ok, r, o, p, exp_res[k], (k == 1));
      end
      stub_ovf = ~exp_bit[k]; stub_pl = 1'b0;
      do_op(k % 2, 2'(k), 16'h0001, 16'h0002, r, o, p, v, ok);
      checks++;
      if (!ok || o !== 1'b0 || p !== 1'b0) begin
        errors++; $display("FAIL select_off op=%0d got ok=%0d ovf=%b pl=%b exp=0 0", k, ok, o, p);
      end
    end
    stub_mode = 1'b0; stub_ovf = 4'b0;
  endtask

  task automatic test_round_robin();
    int grants [4];
    int gcyc [4];
    int ng = 0;
    int cyc = 0;
    bit both = 1'b0;
    do_reset();
    @(negedge clk);
    req_op = 4'b0000; req_a = {16'h0005, 16'h0001}; req_b = {16'h0006, 16'h0002};
    req_valid = 2'b11; rsp_ready = 2'b11;
    #1;
    while (ng < 4 && cyc < 60) begin
      if (req_ready == 2'b11) both = 1'b1;
      if (req_ready != 2'b00) begin grants[ng] = int'(req_ready[1]); gcyc[ng] = cyc; ng++; end
      @(negedge clk); #1; cyc++;
    end
    req_valid = 2'b00;
    cyc = 0;
    while (busy && cyc < 20) begin @(negedge clk); #1; cyc++; end
    rsp_ready = 2'b00;
    checks++;
    if (ng != 4) begin errors++; $display("FAIL rr_count got=%0d exp=4", ng); end
    else begin
      checks++;
      if (grants[0] != 0 || grants[1] != 1 || grants[2] != 0 || grants[3] != 1) begin
        errors++; $display("FAIL rr_order got=%0d%0d%0d%0d exp=0101", grants[0], grants[1], grants[2], grants[3]);
      end
      checks++;
      if (gcyc[1] - gcyc[0] != 4 || gcyc[3] - gcyc[2] != 4) begin
        errors++; $display("FAIL rr_period got=%0d,%0d exp=4,4", gcyc[1] - gcyc[0], gcyc[3] - gcyc[2]);
      end
    end
    checks++;
    if (both) begin errors++; $display("FAIL rr_both_ready got=11 exp=not 11"); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    bit bad = 1'b0;
    @(negedge clk);
    req_valid = 2'b01; req_op[1:0] = 2'b00; req_a[15:0] = 16'h0001; req_b[15:0] = 16'h0002;
    #1;
    while (!req_ready[0] && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    req_valid = 2'b10; req_op[3:2] = 2'b00; req_a[31:16] = 16'h0010; req_b[31:16] = 16'h0020;
    rsp_ready = 2'b10;  // non-owner ready must be ignored
    #1;
    n = 0;
    while (rsp_valid == 2'b00 && n < 20) begin @(negedge clk); #1; n++; end
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 2'b01 || rsp_result !== 16'h0003 || req_ready !== 2'b00 || busy !== 1'b1) bad = 1'b1;
      @(negedge clk); #1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL bp_hold got vld=%b res=%h rdy=%b busy=%b exp=01 0003 00 1", rsp_valid, rsp_result, req_ready, busy);
    end
    rsp_ready = 2'b01;
    @(negedge clk); rsp_ready = 2'b00; #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 2'b00 || req_ready !== 2'b10) begin
      errors++; $display("FAIL bp_release got busy=%b vld=%b rdy=%b exp=0 00 10", busy, rsp_valid, req_ready);
    end
    @(negedge clk); req_valid = 2'b00; #1;
    n = 0;
    while (rsp_valid == 2'b00 && n < 20) begin @(negedge clk); #1; n++; end
    checks++;
    if (rsp_valid !== 2'b10 || rsp_result !== 16'h0030) begin
      errors++; $display("FAIL bp_waiter got vld=%b res=%h exp=10 0030", rsp_valid, rsp_result);
    end
    rsp_ready = 2'b10;
    @(negedge clk); rsp_ready = 2'b00;
  endtask

  task automatic test_reset_mid_settle();
    logic [15:0] r; logic o, p; logic [1:0] v; bit ok;
    bit seen = 1'b0;
    @(negedge clk);
    req_valid = 2'b01; req_op[1:0] = 2'b00; req_a[15:0] = 16'h0100; req_b[15:0] = 16'h0200;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_accept got=%b exp=01", req_ready); end
    @(negedge clk); req_valid = 2'b00; rst = 1'b1;  // in SETTLE
    @(negedge clk); #1;
    checks++;
    if ({busy, rsp_valid, req_ready, rsp_overflow, rsp_prec_lost} !== 7'b0 ||
        {core_num1, core_num2, rsp_result} !== 48'h0) begin
      errors++; $display("FAIL mid_reset got busy=%b vld=%b n1=%h res=%h exp=0 00 0000 0000", busy, rsp_valid, core_num1, rsp_result);
    end
    rst = 1'b0; rsp_ready = 2'b11;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (rsp_valid != 2'b00 || busy) seen = 1'b1;
    end
    rsp_ready = 2'b00;
    checks++;
    if (seen) begin errors++; $display("FAIL mid_no_rsp got=response seen exp=none"); end
    do_op(0, 2'b00, 16'h0007, 16'h0008, r, o, p, v, ok);
    checks++;
    if (!ok || v !== 2'b01 || r !== 16'h000F) begin
      errors++; $display("FAIL mid_recover got ok=%0d vld=%b res=%h exp=1 01 000f", ok, v, r);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = '0;
    test_reset();
    test_single_fixed_add();
    test_fixed_mul();
    test_float();
    test_flag_select();
    test_round_robin();
    test_backpressure();
    test_reset_mid_settle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
